pool_stream_reader: RTL

Frame-serialising reader for the kernel pooler's flat output bus. It accepts one pooled feature map, DEPTH·OX·OY bits wide, through a valid/ready load handshake. It holds the map in an internal register and streams it out one DEPTH-bit element per beat in flat-index order, tagging each beat with its (x, y) coordinate and a last flag. It sits between the combinational pooler and any downstream element-serial consumer, such as a classifier, UART, or memory writer.

---
 rtl/pool_pkg.sv | 18 +
 rtl/pool_index_counter.sv | 64 ++++++
 rtl/pool_stream_reader.sv | 93 +++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared pooling-side definitions: output-geometry helpers and the reader FSM encoding.
package pool_pkg;

   typedef enum logic [0:0] {
      StIdle   = 1'b0,
      StStream = 1'b1
   } pool_state_e;

   function automatic int unsigned pool_out_dim(input int unsigned a, input int unsigned k);
      return a - k + 1;
   endfunction

   // clog2 with a floor of 1 so single-entry dimensions still get a 1-bit field
   function automatic int unsigned pool_clog2(input int unsigned v);
      return (v > 2) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/pool_index_counter.sv
// Flat element index with (x, y) coordinates; y runs fastest and carries into x.
module pool_index_counter
   import pool_pkg::*;
#(
   parameter int unsigned OX = 6,
   parameter int unsigned OY = 6,
   localparam int unsigned N  = OX * OY,
   localparam int unsigned XW = pool_clog2(OX),
   localparam int unsigned YW = pool_clog2(OY),
   localparam int unsigned IW = pool_clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [IW-1:0] idx,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last
);

   logic [IW-1:0] idx_q, idx_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   assign last = (idx_q == IW'(N - 1));

   always_comb begin
      idx_d = idx_q;
      x_d   = x_q;
      y_d   = y_q;
      // Stepping past the final element returns everything to the origin
      if (clr || (inc && last)) begin
         idx_d = '0;
         x_d   = '0;
         y_d   = '0;
      end else if (inc) begin
         idx_d = idx_q + IW'(1);
         if (y_q == YW'(OY - 1)) begin
            y_d = '0;
            x_d = x_q + XW'(1);
         end else begin
            y_d = y_q + YW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
      end else begin
         idx_q <= idx_d;
         x_q   <= x_d;
         y_q   <= y_d;
      end
   end

   assign idx = idx_q;
   assign x   = x_q;
   assign y   = y_q;

endmodule

// File: rtl/pool_stream_reader.sv
// Captures one pooled map through a load handshake and streams it out one element per beat.
module pool_stream_reader
   import pool_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned KX    = 3,
   parameter int unsigned KY    = 3,
   parameter int unsigned AX    = 8,
   parameter int unsigned AY    = 8,
   localparam int unsigned OX   = pool_out_dim(AX, KX),
   localparam int unsigned OY   = pool_out_dim(AY, KY),
   localparam int unsigned N    = OX * OY,
   localparam int unsigned XW   = pool_clog2(OX),
   localparam int unsigned YW   = pool_clog2(OY),
   localparam int unsigned IW   = pool_clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DEPTH*N-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DEPTH-1:0]   out_data,
   output logic [XW-1:0]      out_x,
   output logic [YW-1:0]      out_y,
   output logic               out_last,
   output logic               busy
);

   pool_state_e        state_q, state_d;
   logic [DEPTH*N-1:0] frame_q, frame_d;
   logic [IW-1:0]      idx;
   logic [XW-1:0]      cnt_x;
   logic [YW-1:0]      cnt_y;
   logic               cnt_last;
   logic               accept;
   logic               fire;
   logic [DEPTH-1:0]   elem;

   pool_index_counter #(
      .OX (OX),
      .OY (OY)
   ) u_index (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .inc  (fire),
      .idx  (idx),
      .x    (cnt_x),
      .y    (cnt_y),
      .last (cnt_last)
   );

   always_comb begin
      elem = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (idx == IW'(k)) elem = frame_q[k*DEPTH +: DEPTH];
      end
   end

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      out_valid = (state_q == StStream);
      fire      = out_valid && out_ready;
      // A frame may be taken on the same edge that retires the previous one
      in_ready  = (state_q == StIdle) || (fire && cnt_last);
      accept    = in_valid && in_ready;
      busy      = out_valid;
      out_data  = out_valid ? elem : '0;
      out_x     = out_valid ? cnt_x : '0;
      out_y     = out_valid ? cnt_y : '0;
      out_last  = out_valid && cnt_last;
      if (accept) begin
         frame_d = in_data;
         state_d = StStream;
      end else if (fire && cnt_last) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
      end
   end

endmodule
